// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with a valid/ready stream interface.
// Each of SEGS register stages resolves WIDTH/SEGS bits; all stages stall together.
module csa_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4,
    parameter int SEGS  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);
    localparam int SEG  = WIDTH / SEGS;
    localparam int NBLK = SEG / BLOCK;

    logic                       stall;
    logic [SEGS-1:0]            vld_q, vld_d;
    logic [SEGS-1:0]            c_q, c_d, cin_s;
    logic [SEGS-1:0][WIDTH-1:0] aw_q, aw_d, bw_q, bw_d, a_s, b_s;
    logic                       ovf_q, ovf_d;
    logic                       unused_bw;

    assign stall      = vld_q[SEGS-1] & ~out_ready_i;
    assign in_ready_o = ~stall;

    // Operand words rotate right by one segment per stage: the segment being
    // added always sits in the low bits, and finished sum bits enter at the top,
    // so after the last stage the a-word holds the complete sum in order.
    genvar k;
    generate
        for (k = 0; k < SEGS; k++) begin : g_stg
            logic [SEG-1:0] ssum;
            logic           blk_c;
            logic [BLOCK:0] r0, r1;

            if (k == 0) begin : g_src
                assign a_s[k]   = a_i;
                assign b_s[k]   = b_i ^ {WIDTH{sub_i}};
                assign cin_s[k] = sub_i | cin_i;
                assign vld_d[k] = in_valid_i;
            end else begin : g_src
                assign a_s[k]   = aw_q[k-1];
                assign b_s[k]   = bw_q[k-1];
                assign cin_s[k] = c_q[k-1];
                assign vld_d[k] = vld_q[k-1];
            end

            // Both carry hypotheses per block; the true block carry picks sum and carry-out.
            always_comb begin
                blk_c = cin_s[k];
                ssum  = '0;
                r0    = '0;
                r1    = '0;
                for (int j = 0; j < NBLK; j++) begin
                    r0 = {1'b0, a_s[k][j*BLOCK +: BLOCK]} + {1'b0, b_s[k][j*BLOCK +: BLOCK]};
                    r1 = {1'b0, a_s[k][j*BLOCK +: BLOCK]} + {1'b0, b_s[k][j*BLOCK +: BLOCK]}
                         + {{BLOCK{1'b0}}, 1'b1};
                    ssum[j*BLOCK +: BLOCK] = blk_c ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
                    blk_c = blk_c ? r1[BLOCK] : r0[BLOCK];
                end
            end

            assign c_d[k] = blk_c;

            if (SEG == WIDTH) begin : g_rot
                assign aw_d[k] = ssum;
                assign bw_d[k] = b_s[k];
            end else begin : g_rot
                assign aw_d[k] = {ssum, a_s[k][WIDTH-1:SEG]};
                assign bw_d[k] = {b_s[k][SEG-1:0], b_s[k][WIDTH-1:SEG]};
            end

            // Carry into the MSB is a^b^sum at that bit.
            if (k == SEGS-1) begin : g_ovf
                assign ovf_d = a_s[k][SEG-1] ^ b_s[k][SEG-1] ^ ssum[SEG-1] ^ blk_c;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            aw_q  <= '0;
            bw_q  <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else if (!stall) begin
            vld_q <= vld_d;
            aw_q  <= aw_d;
            bw_q  <= bw_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
        end
    end

    // The last stage's rotated b-word has no consumer.
    assign unused_bw = ^bw_q[SEGS-1];

    assign out_valid_o = vld_q[SEGS-1];
    assign sum_o       = aw_q[SEGS-1];
    assign cout_o      = c_q[SEGS-1];
    assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_csa_pipe_adder.sv
// Scoreboard bench for csa_pipe_adder: default 32/4/2 instance plus a 64/8/4 instance.
module tb_csa_pipe_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, sum;
    logic        w_in_valid, w_in_ready, w_cin, w_out_valid, w_cout, w_ovf;
    logic [63:0] w_a, w_b, w_sum;

    int total  = 0;
    int passed = 0;
    int emitted = 0;
    bit mon_en = 0;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;
    exp_t q[$];

    csa_pipe_adder dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .sum_o(sum), .cout_o(cout), .ovf_o(ovf)
    );

    csa_pipe_adder #(.WIDTH(64), .BLOCK(8), .SEGS(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(w_in_valid), .in_ready_o(w_in_ready),
        .a_i(w_a), .b_i(w_b), .cin_i(w_cin), .sub_i(1'b0), .out_valid_o(w_out_valid),
        .out_ready_i(1'b1), .sum_o(w_sum), .cout_o(w_cout), .ovf_o(w_ovf)
    );

    function automatic exp_t model(logic [31:0] x, logic [31:0] y, logic ci, logic s);
        logic [31:0] yy;
        logic [32:0] r;
        exp_t e;
        yy = s ? ~y : y;
        r = {1'b0, x} + {1'b0, yy} + {32'd0, (s ? 1'b1 : ci)};
        e.sum  = r[31:0];
        e.cout = r[32];
        e.ovf  = (x[31] == yy[31]) && (r[31] != x[31]);
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Every valid output is held against the queue head, so a result that
    // changes while stalled, or arrives out of order, mismatches.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (out_valid) begin
                total++;
                if (q.size() == 0)
                    $display("FAIL sb_extra: out_valid with nothing pending, sum=%h", sum);
                else if ({sum, cout, ovf} !== q[0])
                    $display("FAIL sb_data: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                             sum, cout, ovf, q[0].sum, q[0].cout, q[0].ovf);
                else
                    passed++;
                if (out_ready && q.size() > 0) begin
                    void'(q.pop_front());
                    emitted++;
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else passed++;
        total++; if (sum !== 32'h0) $display("FAIL rst_sum: got %h want 0", sum); else passed++;
        total++; if ({cout, ovf} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {cout, ovf}); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", in_ready); else passed++;
        total++; if (w_out_valid !== 1'b0) $display("FAIL rst_valid64: got %b want 0", w_out_valid); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] ta[4], tb[4], ts[4];
        logic        tc[4], tsub[4], tco[4], tov[4];
        ta = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000};
        tb = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0007, 32'h0000_0001};
        tc = '{1'b0, 1'b1, 1'b1, 1'b1};
        tsub = '{1'b0, 1'b0, 1'b1, 1'b1};
        ts = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
        tco = '{1'b1, 1'b0, 1'b0, 1'b1};
        tov = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            a = ta[i]; b = tb[i]; cin = tc[i]; sub = tsub[i];
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            total++; if (out_valid !== 1'b0) $display("FAIL dir%0d_early: out_valid=%b want 0", i, out_valid); else passed++;
            @(posedge clk); #1;
            total++;
            if ({out_valid, sum, cout, ovf} !== {1'b1, ts[i], tco[i], tov[i]})
                $display("FAIL dir%0d: got v=%b sum=%h cout=%b ovf=%b, want v=1 sum=%h cout=%b ovf=%b",
                         i, out_valid, sum, cout, ovf, ts[i], tco[i], tov[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int start;
        bit ready_ok;
        start = emitted;
        ready_ok = 1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = pick(); b = pick(); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            #1;
            if (in_ready !== 1'b1) ready_ok = 0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        total++; if (!ready_ok) $display("FAIL b2b_ready: in_ready dropped, want always 1"); else passed++;
        total++; if (emitted - start != 10) $display("FAIL b2b_count: got %0d results in 11 cycles, want 10", emitted - start); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int acc, cyc;
        acc = 0;
        cyc = 0;
        while (acc < 100 && cyc < 3000) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            a = pick(); b = pick(); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        total++; if (acc != 100) $display("FAIL stream_accept: got %0d beats accepted, want 100", acc); else passed++;
        total++; if (q.size() != 0) $display("FAIL stream_drain: got %0d pending, want 0", q.size()); else passed++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'h0F0F_0F0F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", out_valid); else passed++;
        total++; if (sum !== 32'h0) $display("FAIL mid_rst_sum: got %h want 0", sum); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", in_ready); else passed++;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_stale%0d: out_valid=%b want 0", i, out_valid); else passed++;
        end
    endtask

    task automatic test_wide();
        logic [64:0] wq[$];
        logic [64:0] r;
        int n, got, first, last;
        w_a = 64'hFFFF_FFFF_FFFF_FFFF; w_b = 64'h1; w_cin = 1'b0; w_in_valid = 1'b1;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            w_in_valid = 1'b0;
            if (w_out_valid && n == 0) n = i;
        end
        total++; if (n != 4) $display("FAIL wide_latency: got %0d edges want 4", n); else passed++;
        // re-run the probe so the result is checked while it is still presented
        w_in_valid = 1'b1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        total++;
        if ({w_out_valid, w_sum, w_cout, w_ovf} !== {1'b1, 64'h0, 1'b1, 1'b0})
            $display("FAIL wide_carry: got v=%b sum=%h cout=%b ovf=%b, want v=1 sum=0 cout=1 ovf=0",
                     w_out_valid, w_sum, w_cout, w_ovf);
        else passed++;
        @(posedge clk); #1;
        got = 0; first = -1; last = -1;
        for (int c = 0; c < 20; c++) begin
            if (c < 10) begin
                w_a = {$urandom, $urandom}; w_b = {$urandom, $urandom};
                w_cin = 1'($urandom_range(0, 1)); w_in_valid = 1'b1;
                r = {1'b0, w_a} + {1'b0, w_b} + {64'd0, w_cin};
                wq.push_back(r);
            end else w_in_valid = 1'b0;
            @(posedge clk); #1;
            if (w_out_valid) begin
                total++;
                if (wq.size() == 0) $display("FAIL wide_extra: unexpected sum=%h", w_sum);
                else if ({w_cout, w_sum} !== wq[0])
                    $display("FAIL wide_data: got cout=%b sum=%h want cout=%b sum=%h",
                             w_cout, w_sum, wq[0][64], wq[0][63:0]);
                else passed++;
                if (wq.size() > 0) void'(wq.pop_front());
                got++;
                if (first < 0) first = c;
                last = c;
            end
        end
        total++; if (got != 10) $display("FAIL wide_count: got %0d want 10", got); else passed++;
        total++; if (first != 3 || last - first != 9)
            $display("FAIL wide_rate: got first=%0d span=%0d want first=3 span=9", first, last - first);
        else passed++;
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        w_in_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stream();
        test_reset_mid();
        test_wide();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
